trng_src_mux: RTL and testbench
===============================

Name: trng_src_mux

Overview:
- Parametrised, registered N-to-1 selector for the TRNG entropy sources (ring-oscillator outputs). It replaces the plain 2:1 combinational select.
- Synchronises every asynchronous source lane into the system clock domain and accepts select changes only through a load strobe.
- After any reset or source switch, it blanks the output for a fixed settle period so that switch glitches and stale synchroniser contents never reach the sampler or post-processing chain.

Parameters:
- N_SRC, 4, number of source lanes (2..16).
- WIDTH, 1, bits per source lane.
- SYNC_STAGES, 2, flip-flop stages per synchroniser (2..4).
- BLANK_CYCLES, 8, clocks dout_valid stays low after reset or an accepted switch (1..255).
- SEL_W, derived localparam = clog2(N_SRC), minimum 1; not user-set.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- src_in  in  N_SRC*WIDTH  source lanes, asynchronous to clk; lane i occupies bits [i*WIDTH +: WIDTH].
- sel_in  in  SEL_W  requested lane index.
- sel_load  in  1  single-cycle strobe to request switching to sel_in.
- dout  out  WIDTH  registered, synchronised data of the selected lane.
- dout_valid  out  1  high when dout is usable entropy.
- busy  out  1  high while blanking.
- sel_cur  out  SEL_W  currently active lane index.
- sel_err  out  1  one-cycle pulse when a load request is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All synchroniser flops clear to 0.
  - sel_cur=0, dout=0, dout_valid=0, sel_err=0.
  - State=BLANK, blank counter=BLANK_CYCLES, busy=1.
- Synchronisers:
  - Every lane passes through SYNC_STAGES flops continuously, whatever the state, so the newly selected lane is already settled when blanking ends.
- FSM has two states, BLANK and RUN.
- BLANK:
  - busy=1, dout_valid=0, dout held at 0.
  - Counter decrements once per clock.
  - On the clock where counter==1: next state RUN, counter=0, dout<=sync[sel_cur], dout_valid<=1, busy<=0.
  - Result: dout_valid is low for exactly BLANK_CYCLES rising edges after reset release or after the accepting edge.
- RUN:
  - dout<=sync[sel_cur] every clock; dout_valid=1.
  - Latency from src_in to dout is SYNC_STAGES+1 clocks.
- sel_load handling, priority top-down, evaluated on a rising edge:
  - In BLANK: request rejected; sel_err=1 for one cycle; sel_cur unchanged; counter not restarted.
  - sel_in >= N_SRC: rejected; sel_err=1 for one cycle; no state change.
  - sel_in == sel_cur (in RUN): no-op, no error; dout_valid stays 1.
  - Otherwise (in RUN): sel_cur<=sel_in, state<=BLANK, counter<=BLANK_CYCLES, dout<=0, dout_valid<=0, busy<=1, all on the same edge.
- sel_err is registered and high for exactly one cycle per rejected strobe. A strobe held high over several cycles is evaluated independently each cycle.
- Reset asserted mid-BLANK or mid-RUN aborts immediately to the reset values above. After release, the full BLANK_CYCLES blanking runs again.
- When N_SRC is a power of two, no out-of-range sel_in exists, so sel_err only ever fires for BLANK rejects.
- No combinational path from any input to any output.

Test Plan:
- Reset release with BLANK_CYCLES=8 and src_in lane0 toggling -> dout_valid first high exactly 8 clocks after the first edge following reset release; busy mirrors ~dout_valid; sel_cur=0.
- RUN state, lane2 driven constant 1, all other lanes 0, sel_in=2, sel_load pulse -> dout_valid low for exactly 8 clocks; then dout=1, sel_cur=2.
- In RUN on lane2, step lane2 from 0 to 1 with SYNC_STAGES=2 -> dout changes exactly 3 clocks after the source edge.
- N_SRC=3, sel_in=3, sel_load -> sel_err pulses for one cycle, sel_cur unchanged, dout_valid stays 1.
- sel_load with sel_in=1 issued 4 clocks into a blanking period -> sel_err pulses, sel_cur unchanged, dout_valid rises at the original 8-clock mark; a separate load of sel_in==sel_cur in RUN -> no error and no blanking.
- rst_n pulsed low for 1 ns during RUN on lane2 -> outputs clear immediately and asynchronously, sel_cur=0, full 8-clock blanking repeats after release.

Source files
------------

// File: rtl/trng_src_mux.sv
// Registered N-to-1 entropy source selector with per-lane synchronisers and
// a blanking window after reset or any accepted source switch.
module trng_src_mux #(
  parameter int N_SRC        = 4,
  parameter int WIDTH        = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int BLANK_CYCLES = 8,
  localparam int SEL_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC*WIDTH-1:0]   src_in,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     sel_load,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic [SEL_W-1:0]         sel_cur,
  output logic                     sel_err
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int              CNT_W      = 8;
  localparam logic [CNT_W-1:0] BLANK_INIT = CNT_W'(BLANK_CYCLES);

  logic [N_SRC*WIDTH-1:0] r_sync [SYNC_STAGES];

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_sel_cur;
  logic [WIDTH-1:0]   r_dout;
  logic               r_dout_valid;
  logic               r_busy;
  logic               r_sel_err;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [WIDTH-1:0]   w_dout_nxt;
  logic               w_valid_nxt;
  logic               w_busy_nxt;
  logic               w_err_nxt;
  logic [WIDTH-1:0]   w_lane;
  logic               w_sel_oob;

  // All lanes are synchronised continuously so a newly chosen lane is settled
  // by the time blanking ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= src_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  always_comb begin
    w_lane = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_sel_cur == SEL_W'(i)) w_lane = r_sync[SYNC_STAGES-1][i*WIDTH +: WIDTH];
    end
  end

  assign w_sel_oob = ({1'b0, sel_in} >= (SEL_W+1)'(N_SRC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= BLANK_INIT;
      r_sel_cur    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b1;
      r_sel_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel_cur    <= w_sel_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_sel_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel_cur;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_dout_valid;
    w_busy_nxt  = r_busy;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_BLANK: begin
        w_dout_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        // Switching is locked out while blanking; the window is never extended.
        w_err_nxt   = sel_load;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_dout_nxt  = w_lane;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        w_dout_nxt  = w_lane;
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (sel_load) begin
          if (w_sel_oob) begin
            w_err_nxt = 1'b1;
          end else if (sel_in != r_sel_cur) begin
            w_sel_nxt   = sel_in;
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = BLANK_INIT;
            w_dout_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = BLANK_INIT;
      end
    endcase
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign sel_cur    = r_sel_cur;
  assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_trng_src_mux.sv
// Bench for trng_src_mux: directed steps plus random traffic against an
// edge-indexed reference model (blanking tracked as an end-edge number).
module tb_trng_src_mux;

  localparam int N_SRC        = 3;
  localparam int WIDTH        = 2;
  localparam int SYNC_STAGES  = 2;
  localparam int BLANK_CYCLES = 8;
  localparam int SEL_W        = 2;
  localparam int SW           = N_SRC * WIDTH;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic [SW-1:0]    src_in   = '0;
  logic [SEL_W-1:0] sel_in   = '0;
  logic             sel_load = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic [SEL_W-1:0] sel_cur;
  logic             sel_err;

  int tests = 0;
  int fails = 0;

  trng_src_mux #(
    .N_SRC(N_SRC), .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_in(src_in), .sel_in(sel_in), .sel_load(sel_load),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .sel_cur(sel_cur), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Reference model: edges since reset release, edge at which output becomes
  // valid, active lane, and the source value seen at every edge.
  int            m_edge;
  int            m_blank_end;
  int            m_sel;
  bit            m_err;
  logic [SW-1:0] m_hist[$];

  function automatic logic [WIDTH-1:0] lane_of(logic [SW-1:0] v, int l);
    return v[l*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_edge      = 0;
    m_blank_end = BLANK_CYCLES;
    m_sel       = 0;
    m_err       = 1'b0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    bit was_valid;
    m_edge++;
    m_hist.push_back(src_in);
    was_valid = (m_edge - 1) >= m_blank_end;
    m_err = 1'b0;
    if (sel_load) begin
      if (!was_valid || int'(sel_in) >= N_SRC) m_err = 1'b1;
      else if (int'(sel_in) != m_sel) begin
        m_sel       = int'(sel_in);
        m_blank_end = m_edge + BLANK_CYCLES;
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] model_dout();
    int k;
    logic [SW-1:0] v;
    if (m_edge < m_blank_end) return '0;
    k = m_edge - SYNC_STAGES;
    v = (k >= 1) ? m_hist[k-1] : '0;
    return lane_of(v, m_sel);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    bit v;
    v = (m_edge >= m_blank_end);
    chk({tag, ".dout"},    32'(dout),       32'(model_dout()));
    chk({tag, ".valid"},   32'(dout_valid), 32'(v));
    chk({tag, ".busy"},    32'(busy),       32'(!v));
    chk({tag, ".sel_cur"}, 32'(sel_cur),    32'(m_sel));
    chk({tag, ".sel_err"}, 32'(sel_err),    32'(m_err));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, ".dout"},    32'(dout),       32'(0));
    chk({tag, ".valid"},   32'(dout_valid), 32'(0));
    chk({tag, ".busy"},    32'(busy),       32'(1));
    chk({tag, ".sel_cur"}, 32'(sel_cur),    32'(0));
    chk({tag, ".sel_err"}, 32'(sel_err),    32'(0));
  endtask

  task automatic pulse_reset(string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic first_valid_after_reset(string tag);
    int first;
    first = 0;
    for (int i = 1; i <= BLANK_CYCLES + 4; i++) begin
      src_in[0 +: WIDTH] = ~src_in[0 +: WIDTH];
      step(tag);
      if (dout_valid === 1'b1 && first == 0) first = i;
    end
    chk({tag, ".first_valid"}, 32'(first), 32'(BLANK_CYCLES));
  endtask

  initial begin
    int lows;
    model_reset();
    #22;
    check_reset_vals("reset");
    rst_n = 1'b1;
    model_reset();

    src_in = 6'b000001;
    first_valid_after_reset("rel");

    // Switch to lane2 holding a constant value.
    src_in   = {2'b01, 2'b00, 2'b00};
    sel_in   = 2'd2;
    sel_load = 1'b1;
    step("sw2");
    sel_load = 1'b0;
    lows = (dout_valid === 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step("sw2_blank");
      if (dout_valid === 1'b0) lows++;
    end
    chk("sw2.blank_len", 32'(lows), 32'(BLANK_CYCLES));
    chk("sw2.dout", 32'(dout), 32'(1));
    chk("sw2.sel_cur", 32'(sel_cur), 32'(2));

    // Source-to-output latency on lane2.
    src_in[4 +: 2] = 2'b00;
    for (int i = 0; i < 4; i++) step("lat_zero");
    src_in[4 +: 2] = 2'b01;
    step("lat1");
    step("lat2");
    chk("lat.early", 32'(dout), 32'(0));
    step("lat3");
    chk("lat.hit", 32'(dout), 32'(1));

    // Out-of-range select.
    sel_in   = 2'd3;
    sel_load = 1'b1;
    step("oob");
    chk("oob.err", 32'(sel_err), 32'(1));
    chk("oob.valid", 32'(dout_valid), 32'(1));
    sel_load = 1'b0;
    step("oob_after");

    // Load during blanking is rejected and does not extend the window.
    sel_in   = 2'd1;
    sel_load = 1'b1;
    step("sw1");
    sel_load = 1'b0;
    for (int i = 0; i < 3; i++) step("sw1_blank");
    sel_in   = 2'd0;
    sel_load = 1'b1;
    step("blank_rej");
    chk("blank_rej.err", 32'(sel_err), 32'(1));
    chk("blank_rej.sel_cur", 32'(sel_cur), 32'(1));
    sel_load = 1'b0;
    for (int i = 0; i < 6; i++) step("blank_rej_after");
    chk("blank_rej.valid_mark", 32'(dout_valid), 32'(1));

    // Reload of the current lane in RUN.
    sel_in   = 2'd1;
    sel_load = 1'b1;
    step("same");
    chk("same.err", 32'(sel_err), 32'(0));
    chk("same.valid", 32'(dout_valid), 32'(1));
    sel_load = 1'b0;
    step("same_after");

    // Random traffic, including held strobes and out-of-range selects.
    for (int i = 0; i < 400; i++) begin
      src_in   = SW'($urandom);
      sel_in   = SEL_W'($urandom_range(0, 3));
      sel_load = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    // Reset mid-RUN on lane2.
    sel_load = 1'b0;
    for (int i = 0; i < 10; i++) step("settle");
    sel_in   = 2'd2;
    sel_load = 1'b1;
    step("to2");
    sel_load = 1'b0;
    for (int i = 0; i < 10; i++) step("run2");
    pulse_reset("rst_run");
    first_valid_after_reset("rst_run");

    // Reset mid-BLANK.
    sel_in   = 2'd1;
    sel_load = 1'b1;
    step("to1");
    sel_load = 1'b0;
    for (int i = 0; i < 3; i++) step("blank1");
    pulse_reset("rst_blank");
    first_valid_after_reset("rst_blank");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
